// File: rtl/fp_ci_initiator.sv
// Initiator side of a multi-cycle custom-instruction port: queues operand pairs,
// issues one start/done transaction per pair, and returns results via valid/ready.
module fp_ci_initiator #(
    parameter int unsigned    DW      = 32,
    parameter int unsigned    DEPTH   = 4,
    parameter int unsigned    TIMEOUT = 255,
    parameter logic [DW-1:0]  NAN_VAL = 32'h7FC00000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_dataa,
    input  logic [DW-1:0] in_datab,
    output logic          in_ready,
    output logic          ci_clk_en,
    output logic          ci_start,
    output logic [DW-1:0] ci_dataa,
    output logic [DW-1:0] ci_datab,
    input  logic [DW-1:0] ci_result,
    input  logic          ci_done,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    input  logic          res_ready,
    input  logic          err_clear,
    output logic          busy,
    output logic          timeout_err,
    output logic [15:0]   issued_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [CW-1:0] wait_cnt;
    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;

    // The extra pointer bit separates a full ring from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = in_valid && !full;
    assign pop   = (state == S_ISSUE);

    assign in_ready  = !full;
    assign ci_clk_en = !reset;
    assign ci_start  = (state == S_ISSUE);
    assign res_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr[AW-1:0]] <= in_dataa;
            mem_b[wr_ptr[AW-1:0]] <= in_datab;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wait_cnt     <= '0;
            ci_dataa     <= '0;
            ci_datab     <= '0;
            res_data     <= '0;
            timeout_err  <= 1'b0;
            issued_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            // A timeout raised below overrides a simultaneous clear.
            if (err_clear) timeout_err <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    // Operands are latched here so they are valid during the start pulse.
                    if (!empty) begin
                        ci_dataa <= mem_a[rd_ptr[AW-1:0]];
                        ci_datab <= mem_b[rd_ptr[AW-1:0]];
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    issued_count <= issued_count + 16'd1;
                    wait_cnt     <= '0;
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (ci_done) begin
                        res_data <= ci_result;
                        state    <= S_RESP;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        res_data    <= NAN_VAL;
                        timeout_err <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (res_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
